// File: rtl/m_arbiter_port.sv
// Master-side endpoint of the arbitration handshake: turns a core transfer request into
// arbiter-facing id/com_state/done signals and follows WAIT/STOP_S/STOP_P/CLEAR commands.
module m_arbiter_port #(
    parameter int NO_SLAVES   = 3,
    parameter int S_ID_WIDTH  = $clog2(NO_SLAVES + 1),
    parameter int LEN_WIDTH   = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  core_req,
    input  logic [S_ID_WIDTH-1:0] core_slave_id,
    input  logic [LEN_WIDTH-1:0]  core_len,
    input  logic                  beat,
    input  logic                  slave_ack,
    input  logic                  slave_nak,
    input  logic [1:0]            cmd,
    output logic [S_ID_WIDTH-1:0] id,
    output logic [1:0]            com_state,
    output logic                  done,
    output logic                  core_grant,
    output logic                  core_halt,
    output logic                  core_stop_kind,
    output logic                  core_done,
    output logic                  core_err,
    output logic [LEN_WIDTH-1:0]  remaining
);

    localparam logic [1:0] CMD_WAIT   = 2'b00;
    localparam logic [1:0] CMD_STOP_S = 2'b01;
    localparam logic [1:0] CMD_STOP_P = 2'b10;
    localparam logic [1:0] CMD_CLEAR  = 2'b11;

    localparam logic [1:0] CS_END_COM  = 2'b00;
    localparam logic [1:0] CS_NAK      = 2'b01;
    localparam logic [1:0] CS_WAIT_ACK = 2'b10;
    localparam logic [1:0] CS_COM      = 2'b11;

    localparam int                  CNT_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [S_ID_WIDTH:0] MAX_ID   = (S_ID_WIDTH + 1)'(NO_SLAVES);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ACK,
        S_COM,
        S_STOP,
        S_HOLD,
        S_NAK
    } state_e;

    state_e                  state_q, state_d;
    logic [S_ID_WIDTH-1:0]   id_q, id_d;
    logic [LEN_WIDTH-1:0]    remaining_q, remaining_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    kind_q, kind_d;
    logic                    core_done_q, core_done_d;
    logic                    core_err_q, core_err_d;
    logic [1:0]              com_state_q;
    logic                    core_grant_q;
    logic                    core_halt_q;

    logic                    stop_cmd;
    logic                    req_valid;

    assign stop_cmd  = (cmd == CMD_STOP_S) || (cmd == CMD_STOP_P);
    assign req_valid = core_req && (core_slave_id != '0) && (core_len != '0)
                       && ({1'b0, core_slave_id} <= MAX_ID);

    function automatic logic [1:0] com_state_of(input state_e s);
        logic [1:0] cs;
        cs = CS_END_COM;
        case (s)
            S_REQ, S_ACK, S_HOLD: cs = CS_WAIT_ACK;
            S_COM, S_STOP:        cs = CS_COM;
            S_NAK:                cs = CS_NAK;
            default:              cs = CS_END_COM;
        endcase
        return cs;
    endfunction

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        remaining_d = remaining_q;
        cnt_d       = cnt_q;
        kind_d      = kind_q;
        core_done_d = 1'b0;
        core_err_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d     = S_REQ;
                    id_d        = core_slave_id;
                    remaining_d = core_len;
                end
            end
            S_REQ: begin
                if (cmd == CMD_CLEAR) begin
                    state_d = S_ACK;
                    cnt_d   = '0;
                end
            end
            S_ACK: begin
                // Ack takes priority over both nak and the timeout on the same cycle.
                if (slave_ack) begin
                    state_d = S_COM;
                end else if (slave_nak || (cnt_q == CNT_LAST)) begin
                    state_d = S_NAK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_COM: begin
                if (beat) begin
                    remaining_d = remaining_q - LEN_ONE;
                end
                // Completion beats a simultaneous stop, so a finished transfer never halts.
                if (beat && (remaining_q == LEN_ONE)) begin
                    state_d     = S_IDLE;
                    id_d        = '0;
                    core_done_d = 1'b1;
                end else if (stop_cmd) begin
                    state_d = S_STOP;
                    kind_d  = (cmd == CMD_STOP_S);
                end
            end
            S_STOP: begin
                if (!stop_cmd) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cmd == CMD_CLEAR) begin
                    state_d = S_ACK;
                    cnt_d   = '0;
                end
            end
            S_NAK: begin
                if (cmd == CMD_WAIT) begin
                    state_d     = S_IDLE;
                    id_d        = '0;
                    remaining_d = '0;
                    core_done_d = 1'b1;
                    core_err_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q      <= S_IDLE;
            id_q         <= '0;
            remaining_q  <= '0;
            cnt_q        <= '0;
            kind_q       <= 1'b0;
            core_done_q  <= 1'b0;
            core_err_q   <= 1'b0;
            com_state_q  <= CS_END_COM;
            core_grant_q <= 1'b0;
            core_halt_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            remaining_q  <= remaining_d;
            cnt_q        <= cnt_d;
            kind_q       <= kind_d;
            core_done_q  <= core_done_d;
            core_err_q   <= core_err_d;
            com_state_q  <= com_state_of(state_d);
            core_grant_q <= (state_d == S_ACK) || (state_d == S_COM);
            core_halt_q  <= (state_d == S_STOP) || (state_d == S_HOLD);
        end
    end

    // A stop aimed at a port with nothing to suspend is acknowledged at once so the arbiter never stalls.
    assign done = (state_q == S_STOP)
                  || (stop_cmd && ((state_q == S_IDLE) || (state_q == S_REQ) || (state_q == S_NAK)));

    assign id             = id_q;
    assign com_state      = com_state_q;
    assign core_grant     = core_grant_q;
    assign core_halt      = core_halt_q;
    assign core_stop_kind = kind_q;
    assign core_done      = core_done_q;
    assign core_err       = core_err_q;
    assign remaining      = remaining_q;

endmodule
